// File: rtl/mem_arbiter_ctrl.sv
// Round-robin arbiter and SETUP/ACCESS/HOLD strobe sequencer for an asynchronous
// SRAM shared by a read-only fetch port (A) and a read/write load/store port (B).
module mem_arbiter_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs_n,
  output logic                  mem_we_n,
  output logic                  mem_oe_n,
  output logic                  busy
);

  localparam logic [7:0] LP_CNT_LOAD = 8'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_grant_a;
  logic                  w_grant_b;
  logic                  w_cnt_done;
  logic                  w_op_we;

  logic                  r_last_b;
  logic                  r_own_b;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_mem_drive;
  logic [7:0]            r_cnt;
  logic                  r_cs_n;
  logic                  r_oe_n;
  logic                  r_we_n;
  logic                  r_busy;
  logic                  r_a_ack;
  logic                  r_b_ack;
  logic [DATA_WIDTH-1:0] r_a_rdata;
  logic [DATA_WIDTH-1:0] r_b_rdata;

  // Arbitration and next-state decode; on a tie the port that did not win last time is granted.
  always_comb begin
    w_grant_a  = 1'b0;
    w_grant_b  = 1'b0;
    w_next     = r_state;
    w_cnt_done = (r_cnt == 8'd0);
    w_op_we    = r_we;
    if (b_req && (!a_req || !r_last_b)) begin
      w_grant_b = 1'b1;
    end else begin
      w_grant_b = 1'b0;
    end
    w_grant_a = a_req && !w_grant_b;
    if (r_state == S_IDLE) begin
      w_op_we = w_grant_b && b_we;
    end else begin
      w_op_we = r_we;
    end
    case (r_state)
      S_IDLE: begin
        if (w_grant_a || w_grant_b) begin
          w_next = S_SETUP;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: begin
        if (w_cnt_done) begin
          w_next = S_HOLD;
        end else begin
          w_next = S_ACCESS;
        end
      end
      S_HOLD:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latch the granted request; requester inputs are ignored until the next IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_b   <= 1'b1;
      r_own_b    <= 1'b0;
      r_we       <= 1'b0;
      r_mem_addr <= '0;
      r_wdata    <= '0;
    end else if ((r_state == S_IDLE) && (w_grant_a || w_grant_b)) begin
      r_last_b   <= w_grant_b;
      r_own_b    <= w_grant_b;
      r_we       <= w_grant_b && b_we;
      r_mem_addr <= w_grant_b ? b_addr : a_addr;
      r_wdata    <= w_grant_b ? b_wdata : '0;
    end
  end

  // Strobes are decoded from the next state so they leave flops without glitches;
  // write data stays on the bus from SETUP through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_mem_drive <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= 8'd0;
    end else begin
      r_cs_n      <= (w_next != S_ACCESS);
      r_oe_n      <= !((w_next == S_ACCESS) && !r_we);
      r_we_n      <= !((w_next == S_ACCESS) && r_we);
      r_mem_drive <= (w_next != S_IDLE) && w_op_we;
      r_busy      <= (w_next != S_IDLE);
      if (r_state == S_SETUP) begin
        r_cnt <= LP_CNT_LOAD;
      end else if ((r_state == S_ACCESS) && !w_cnt_done) begin
        r_cnt <= r_cnt - 8'd1;
      end
    end
  end

  // Capture read data on the last ACCESS edge and pulse the owner's ack through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_ack   <= 1'b0;
      r_b_ack   <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      r_a_ack <= (r_state == S_ACCESS) && w_cnt_done && !r_own_b;
      r_b_ack <= (r_state == S_ACCESS) && w_cnt_done && r_own_b;
      if ((r_state == S_ACCESS) && w_cnt_done && !r_we) begin
        if (r_own_b) begin
          r_b_rdata <= mem_data;
        end else begin
          r_a_rdata <= mem_data;
        end
      end
    end
  end

  assign mem_data = r_mem_drive ? r_wdata : {DATA_WIDTH{1'bz}};
  assign mem_addr = r_mem_addr;
  assign mem_cs_n = r_cs_n;
  assign mem_oe_n = r_oe_n;
  assign mem_we_n = r_we_n;
  assign busy     = r_busy;
  assign a_ack    = r_a_ack;
  assign b_ack    = r_b_ack;
  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Scoreboard bench for mem_arbiter_ctrl: directed requests push expected acks,
// a negedge monitor pops and compares them and watches the SRAM strobe invariants.
module tb_mem_arbiter_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 2;
  localparam int P  = W + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic          a_ack;
  logic [DW-1:0] a_rdata;
  logic          b_req = 1'b0;
  logic          b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          b_ack;
  logic [DW-1:0] b_rdata;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  logic          mem_cs_n;
  logic          mem_we_n;
  logic          mem_oe_n;
  logic          busy;

  mem_arbiter_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_cs_n(mem_cs_n),
    .mem_we_n(mem_we_n), .mem_oe_n(mem_oe_n), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: drives the bus only while selected and output-enabled
  logic [DW-1:0] sram [0:255];
  assign mem_data = (!mem_cs_n && !mem_oe_n) ? sram[mem_addr[7:0]] : {DW{1'bz}};
  always @(posedge clk) begin
    if (!rst_n) begin
      sram[8'h20] <= 32'h12345678;
      sram[8'h30] <= 32'hA5A5A5A5;
    end else if (!mem_cs_n && !mem_we_n) begin
      sram[mem_addr[7:0]] <= mem_data;
    end
  end

  typedef struct {
    bit            rd;
    logic [DW-1:0] data;
    int            at;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: scoreboard pops on ack plus strobe/bus invariants
  logic [DW-1:0] held_a = '0;
  logic [DW-1:0] held_b = '0;
  logic          prev_cs_n = 1'b1;
  logic          prev_we_n = 1'b1;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;
  int            run = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      held_a    = '0;
      held_b    = '0;
      prev_cs_n = 1'b1;
      prev_we_n = 1'b1;
      run       = 0;
    end else begin
      if (a_ack || b_ack) begin
        check("ack_exclusive", {63'd0, a_ack & b_ack}, 64'd0);
        check("busy_at_ack", {63'd0, busy}, 64'd1);
      end
      if (a_ack) begin
        if (qa.size() == 0) begin
          check("a_ack_unexpected", 64'd1, 64'd0);
        end else begin
          mon_e = qa.pop_front();
          check("a_ack_cycle", 64'(cyc), 64'(mon_e.at));
          check("a_rdata", 64'(a_rdata), 64'(mon_e.data));
          held_a = mon_e.data;
          check("b_rdata_kept_on_a", 64'(b_rdata), 64'(held_b));
        end
      end
      if (b_ack) begin
        if (qb.size() == 0) begin
          check("b_ack_unexpected", 64'd1, 64'd0);
        end else begin
          mon_e = qb.pop_front();
          check("b_ack_cycle", 64'(cyc), 64'(mon_e.at));
          if (mon_e.rd) begin
            check("b_rdata", 64'(b_rdata), 64'(mon_e.data));
            held_b = mon_e.data;
          end else begin
            check("b_rdata_kept_on_write", 64'(b_rdata), 64'(held_b));
          end
          check("a_rdata_kept_on_b", 64'(a_rdata), 64'(held_a));
        end
      end
      if (!mem_oe_n || !mem_we_n) begin
        check("oe_we_not_both_low", {63'd0, !mem_oe_n && !mem_we_n}, 64'd0);
        check("cs_low_with_strobe", {63'd0, mem_cs_n}, 64'd0);
      end
      if (!mem_oe_n) check("no_drive_in_read", {63'd0, dut.r_mem_drive}, 64'd0);
      if (!mem_cs_n || !prev_cs_n) check("addr_stable", 64'(mem_addr), 64'(prev_addr));
      if (!mem_we_n || !prev_we_n) check("wdata_stable", 64'(mem_data), 64'(prev_data));
      if (!mem_cs_n) begin
        run = run + 1;
      end else if (!prev_cs_n) begin
        check("cs_low_len", 64'(run), 64'(W));
        run = 0;
      end
      prev_cs_n = mem_cs_n;
      prev_we_n = mem_we_n;
      prev_addr = mem_addr;
      prev_data = mem_data;
    end
  end

  task automatic wait_ack(input bit pb);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (pb ? b_ack : a_ack) return;
    end
    check(pb ? "b_ack_timeout" : "a_ack_timeout", 64'd1, 64'd0);
  endtask

  // One request from an idle controller: ack expected W+2 cycles after req
  task automatic single(input bit pb, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rexp);
    @(posedge clk); #1;
    if (pb) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
      qb.push_back('{rd: !we, data: rexp, at: cyc + W + 2});
    end else begin
      a_req = 1'b1; a_addr = addr;
      qa.push_back('{rd: 1'b1, data: rexp, at: cyc + W + 2});
    end
    wait_ack(pb);
    a_req = 1'b0;
    b_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int c;
    int na;
    int nb;
    logic [DW-1:0] wexp;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", {63'd0, mem_cs_n}, 64'd1);
    check("rst_we_n", {63'd0, mem_we_n}, 64'd1);
    check("rst_oe_n", {63'd0, mem_oe_n}, 64'd1);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_acks", {62'd0, a_ack, b_ack}, 64'd0);
    check("rst_rdata", {a_rdata, b_rdata}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_bus_released", {63'd0, dut.r_mem_drive}, 64'd0);
    rst_n = 1'b1;

    // Both ports requesting: A wins the first tie, then grants alternate
    @(posedge clk); #1;
    c = cyc;
    a_req = 1'b1; a_addr = 32'h30;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h40; b_wdata = 32'hCAFEF00D;
    qa.push_back('{rd: 1'b1, data: 32'hA5A5A5A5, at: c + W + 2});
    qb.push_back('{rd: 1'b0, data: 32'h0, at: c + W + 2 + P});
    qa.push_back('{rd: 1'b1, data: 32'hA5A5A5A5, at: c + W + 2 + 2 * P});
    qb.push_back('{rd: 1'b0, data: 32'h0, at: c + W + 2 + 3 * P});
    na = 0;
    nb = 0;
    for (int i = 0; i < 60 && nb < 2; i++) begin
      @(posedge clk); #1;
      if (a_ack) begin
        na++;
        if (na == 2) a_req = 1'b0;
      end
      if (b_ack) begin
        nb++;
        if (nb == 2) b_req = 1'b0;
      end
    end
    check("alt_acks", {32'(na), 32'(nb)}, {32'd2, 32'd2});
    @(posedge clk); #1;
    check("sram_40", 64'(sram[8'h40]), 64'h00000000CAFEF00D);

    single(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0);
    check("sram_10", 64'(sram[8'h10]), 64'h00000000DEADBEEF);
    single(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
    single(1'b1, 1'b0, 32'h20, 32'h0, 32'h12345678);

    // Back-to-back B writes with req held: one ack every W+3 cycles
    @(posedge clk); #1;
    c = cyc;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h0; b_wdata = 32'h0BAD0000;
    for (int k = 0; k < 4; k++) qb.push_back('{rd: 1'b0, data: 32'h0, at: c + W + 2 + k * P});
    nb = 0;
    for (int i = 0; i < 80 && nb < 4; i++) begin
      @(posedge clk); #1;
      if (b_ack) begin
        nb++;
        if (nb == 4) begin
          b_req = 1'b0;
        end else begin
          b_addr = 32'(nb);
          b_wdata = 32'h0BAD0000 + 32'(nb);
        end
      end
    end
    check("b2b_acks", 64'(nb), 64'd4);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      wexp = 32'h0BAD0000 + 32'(k);
      check("b2b_sram", 64'(sram[k]), 64'(wexp));
    end

    // Reset in the middle of a write ACCESS: strobes high and bus released at once
    @(posedge clk); #1;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h50; b_wdata = 32'h11111111;
    for (int i = 0; i < 10 && mem_cs_n; i++) begin
      @(posedge clk); #1;
    end
    check("reached_access", {63'd0, mem_we_n}, 64'd0);
    #1;
    b_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_strobes", {61'd0, mem_cs_n, mem_we_n, mem_oe_n}, 64'd7);
    check("midrst_bus_released", {63'd0, dut.r_mem_drive}, 64'd0);
    check("midrst_no_ack", {62'd0, a_ack, b_ack}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    check("post_rst_rdata", {a_rdata, b_rdata}, 64'd0);
    check("post_rst_strobes", {61'd0, mem_cs_n, mem_we_n, mem_oe_n}, 64'd7);

    check("qa_drained", 64'(qa.size()), 64'd0);
    check("qb_drained", 64'(qb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter_ctrl.md
Name: mem_arbiter_ctrl

Overview:
Sequences the asynchronous active-low SRAM (Address, inout Data, CS/WE/OE) on behalf of two requesters: port A is the read-only instruction fetch and port B is the read/write load/store unit. It arbitrates between them round-robin and generates glitch-free CS_n/OE_n/WE_n timing with setup, programmable access-wait and hold phases. It owns the shared tristate data bus and returns registered read data with a one-cycle ack.

Parameters:
ADDR_WIDTH, 32, width of requester and memory address.
DATA_WIDTH, 32, width of data words.
WAIT_CYCLES, 1, cycles strobes stay active in ACCESS; legal range 1..255.

Ports:
clk  input  1  system clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
a_req  input  1  port A read request, level; held until a_ack.
a_addr  input  ADDR_WIDTH  port A read address.
a_ack  output  1  one-cycle pulse: port A access complete, a_rdata valid.
a_rdata  output  DATA_WIDTH  port A read data, held until next A read completes.
b_req  input  1  port B request, level; held until b_ack.
b_we  input  1  port B: 1 = write, 0 = read.
b_addr  input  ADDR_WIDTH  port B address.
b_wdata  input  DATA_WIDTH  port B write data.
b_ack  output  1  one-cycle pulse: port B access complete.
b_rdata  output  DATA_WIDTH  port B read data, held until next B read completes.
mem_addr  output  ADDR_WIDTH  SRAM address.
mem_data  inout  DATA_WIDTH  SRAM data bus; driven only during writes, else high-Z.
mem_cs_n  output  1  SRAM chip select, active low.
mem_we_n  output  1  SRAM write enable, active low.
mem_oe_n  output  1  SRAM output enable, active low.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: mem_cs_n = mem_we_n = mem_oe_n = 1, mem_data high-Z, mem_addr = 0, a_ack = b_ack = 0, a_rdata = b_rdata = 0, busy = 0, state IDLE, last_grant = B (so A wins the first tie).
- All memory-side outputs come directly from flops. No combinational path exists from req to strobes.
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- IDLE: if a_req or b_req is high, grant and go to SETUP. If both are high, grant the port that is not last_grant, then update last_grant. The granted port's addr, we (A forces we = 0) and wdata are latched. Requester inputs are ignored after latching.
- SETUP (1 cycle): mem_addr = latched address, strobes all high. For a write, mem_data is driven with the latched wdata from this state onward.
- ACCESS (WAIT_CYCLES cycles, counter loaded on SETUP→ACCESS):
  - Read: mem_cs_n = 0, mem_oe_n = 0, mem_we_n = 1.
  - Write: mem_cs_n = 0, mem_we_n = 0, mem_oe_n = 1.
  - On the final ACCESS cycle edge, mem_data is captured into the owner's rdata register (reads only).
- HOLD (1 cycle): all strobes high. Address and write data remain driven. The owner's ack = 1, and its rdata is already valid in this cycle. The next state is always IDLE.
- Per-access latency: IDLE-grant edge to ack is 1 + WAIT_CYCLES cycles after SETUP entry. Total cycles per access = WAIT_CYCLES + 3. With both ports continuously requesting, grants strictly alternate.
- Invariants:
  - mem_oe_n and mem_we_n are never both low.
  - mem_data is never driven while mem_oe_n = 0.
  - Address and write data are stable for the whole window where CS_n is low, plus one cycle either side.
- Requester may keep req high after ack to request again; it is re-arbitrated in the following IDLE cycle. A req dropped before grant is simply not served. There is no cancel after grant.
- Async reset mid-access: strobes go high and the bus is released immediately, no ack is issued, and the transaction is lost. The requester must reissue it.
- rdata of the non-owner port is never modified. A write never modifies b_rdata.

Test Plan:
- Reset: assert rst_n=0 during an ACCESS write → same-delta mem_cs_n/we_n/oe_n = 1, mem_data = Z, no ack; after release busy = 0.
- WAIT_CYCLES=2: B write addr 0x10 data 0xDEADBEEF → SETUP 1 cycle, CS_n/WE_n low exactly 2 cycles with data driven, b_ack pulse in cycle 5 after req; model word 0x10 = 0xDEADBEEF.
- WAIT_CYCLES=2: A read addr 0x10 after above → OE_n/CS_n low 2 cycles, bus never driven by controller, a_ack with a_rdata = 0xDEADBEEF.
- Simultaneous a_req and b_req held high for 4 accesses → grant order A, B, A, B, each ack separated by 5 cycles, OE_n/WE_n never low together.
- B read addr 0x20 (preloaded 0x12345678) while A idle → b_rdata = 0x12345678, a_rdata unchanged.
- WAIT_CYCLES=1 back-to-back B writes 0x0..0x3 with req held → 4 acks at 4-cycle spacing, memory contents match.
